// File: rtl/seq_demux.sv
// seq_demux: registered 1-to-2**S demultiplexer with per-lane one-entry
// holding registers and valid/ready handshakes. The target lane is either
// in_sel (explicit mode) or an internal round-robin pointer (rr_mode=1).
// The pointer never skips a lane, so a time-division stream from a stepped
// recurse_mux select is rebuilt lane by lane in order.
module seq_demux #(
   parameter int S = 2,
   parameter int T = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [T-1:0]         in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [S-1:0]         in_sel,
   input  logic                 rr_mode,
   output logic [(2**S)*T-1:0]  out_data,
   output logic [2**S-1:0]      out_valid,
   input  logic [2**S-1:0]      out_ready,
   output logic [S-1:0]         ptr,
   output logic                 frame_done
);

   localparam int N = 2**S;
   localparam logic [S-1:0] PTR_LAST = S'(N - 1);

   // Registered state
   logic [N*T-1:0] out_data_r;
   logic [N-1:0]   out_valid_r;
   logic [S-1:0]   ptr_r;
   logic           frame_done_r;

   // Combinational next-state and handshake signals
   logic [S-1:0]   tgt_s;
   logic           in_ready_s;
   logic           accept_s;
   logic [N-1:0]   load_s;
   logic [N-1:0]   drain_s;
   logic [N-1:0]   valid_nxt_s;
   logic [N*T-1:0] data_nxt_s;
   logic [S-1:0]   ptr_nxt_s;
   logic           frame_done_nxt_s;

   // Pick the target lane and derive the input handshake; in_ready looks only
   // at lane state and out_ready, never at in_valid.
   always_comb begin
      tgt_s      = in_sel;
      in_ready_s = 1'b1;
      accept_s   = 1'b0;
      if (rr_mode) begin
         tgt_s = ptr_r;
      end else begin
         tgt_s = in_sel;
      end
      in_ready_s = ~out_valid_r[tgt_s] | out_ready[tgt_s];
      accept_s   = in_valid & in_ready_s;
   end

   // Decode per-lane load and drain; a load wins over a drain on the same
   // lane so a simultaneous refill keeps the lane valid without a bubble.
   always_comb begin
      load_s  = {N{1'b0}};
      drain_s = out_valid_r & out_ready;
      for (int k = 0; k < N; k++) begin
         if (accept_s && (tgt_s == S'(k))) begin
            load_s[k] = 1'b1;
         end else begin
            load_s[k] = 1'b0;
         end
      end
      valid_nxt_s = (out_valid_r & ~drain_s) | load_s;
   end

   // Lane data only changes on a load; a drained lane keeps its last word,
   // and a stalled lane is therefore held stable.
   always_comb begin
      data_nxt_s = out_data_r;
      for (int k = 0; k < N; k++) begin
         if (load_s[k]) begin
            data_nxt_s[k*T +: T] = in_data;
         end else begin
            data_nxt_s[k*T +: T] = out_data_r[k*T +: T];
         end
      end
   end

   // Round-robin pointer steps only on an accepted round-robin beat; the
   // frame-done pulse is raised for the beat that lands in the last lane.
   always_comb begin
      ptr_nxt_s        = ptr_r;
      frame_done_nxt_s = 1'b0;
      if (accept_s && rr_mode) begin
         ptr_nxt_s = ptr_r + S'(1);
         if (ptr_r == PTR_LAST) begin
            frame_done_nxt_s = 1'b1;
         end else begin
            frame_done_nxt_s = 1'b0;
         end
      end else begin
         ptr_nxt_s        = ptr_r;
         frame_done_nxt_s = 1'b0;
      end
   end

   // State register; reset drops every held word and any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r   <= {(N*T){1'b0}};
         out_valid_r  <= {N{1'b0}};
         ptr_r        <= {S{1'b0}};
         frame_done_r <= 1'b0;
      end else begin
         out_data_r   <= data_nxt_s;
         out_valid_r  <= valid_nxt_s;
         ptr_r        <= ptr_nxt_s;
         frame_done_r <= frame_done_nxt_s;
      end
   end

   assign out_data   = out_data_r;
   assign out_valid  = out_valid_r;
   assign ptr        = ptr_r;
   assign frame_done = frame_done_r;
   assign in_ready   = in_ready_s;

endmodule

// File: tb/tb_seq_demux.sv
// Directed bench for seq_demux: one S=2,T=1 instance and one S=3,T=4
// instance, each shadowed by a lane-occupancy model that is compared on
// every cycle, plus hand-computed literal checks along the test plan.
module tb_seq_demux;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- instance A: S=2, T=1 ----------------
   logic       a_in_data = 1'b0, a_in_valid = 1'b0, a_rr = 1'b0;
   logic [1:0] a_in_sel = 2'd0;
   logic [3:0] a_oready = 4'd0;
   logic       a_in_ready, a_fd;
   logic [3:0] a_out_data, a_out_valid;
   logic [1:0] a_ptr;

   seq_demux #(.S(2), .T(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .in_sel(a_in_sel), .rr_mode(a_rr),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_oready),
      .ptr(a_ptr), .frame_done(a_fd));

   // ---------------- instance B: S=3, T=4 ----------------
   logic [3:0]  b_in_data = 4'd0;
   logic        b_in_valid = 1'b0, b_rr = 1'b0;
   logic [2:0]  b_in_sel = 3'd0;
   logic [7:0]  b_oready = 8'd0;
   logic        b_in_ready, b_fd;
   logic [31:0] b_out_data;
   logic [7:0]  b_out_valid;
   logic [2:0]  b_ptr;

   seq_demux #(.S(3), .T(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .in_sel(b_in_sel), .rr_mode(b_rr),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_oready),
      .ptr(b_ptr), .frame_done(b_fd));

   // ---------------- model: lanes as full flags + words, ptr = rr beats mod N
   bit ma_full [4]; int ma_word [4]; int ma_rr; bit ma_fd;
   int ma_tgt; bit ma_ready;
   logic [3:0] ma_valid_v, ma_data_v;

   bit mb_full [8]; int mb_word [8]; int mb_rr; bit mb_fd;
   int mb_tgt; bit mb_ready;
   logic [7:0]  mb_valid_v;
   logic [31:0] mb_data_v;

   always_comb begin
      ma_tgt = a_rr ? (ma_rr % 4) : int'(a_in_sel);
      ma_ready = !ma_full[ma_tgt] || a_oready[ma_tgt];
      for (int k = 0; k < 4; k++) begin
         ma_valid_v[k] = ma_full[k];
         ma_data_v[k]  = ma_word[k][0];
      end
      mb_tgt = b_rr ? (mb_rr % 8) : int'(b_in_sel);
      mb_ready = !mb_full[mb_tgt] || b_oready[mb_tgt];
      for (int k = 0; k < 8; k++) begin
         mb_valid_v[k]       = mb_full[k];
         mb_data_v[k*4 +: 4] = mb_word[k][3:0];
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin ma_full[k] <= 1'b0; ma_word[k] <= 0; end
         for (int k = 0; k < 8; k++) begin mb_full[k] <= 1'b0; mb_word[k] <= 0; end
         ma_rr <= 0; ma_fd <= 1'b0; mb_rr <= 0; mb_fd <= 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) if (ma_full[k] && a_oready[k]) ma_full[k] <= 1'b0;
         for (int k = 0; k < 8; k++) if (mb_full[k] && b_oready[k]) mb_full[k] <= 1'b0;
         if (a_in_valid && ma_ready) begin
            ma_full[ma_tgt] <= 1'b1;
            ma_word[ma_tgt] <= int'(a_in_data);
         end
         if (b_in_valid && mb_ready) begin
            mb_full[mb_tgt] <= 1'b1;
            mb_word[mb_tgt] <= int'(b_in_data);
         end
         ma_fd <= a_in_valid && ma_ready && a_rr && ((ma_rr + 1) % 4 == 0);
         mb_fd <= b_in_valid && mb_ready && b_rr && ((mb_rr + 1) % 8 == 0);
         if (a_in_valid && ma_ready && a_rr) ma_rr <= ma_rr + 1;
         if (b_in_valid && mb_ready && b_rr) mb_rr <= mb_rr + 1;
      end
   end

   // Per-cycle comparison shortly after each rising edge
   always @(posedge clk) begin
      #1;
      check("cycle_a", {a_in_ready, a_fd, a_ptr, a_out_valid, a_out_data},
            {ma_ready, ma_fd, 2'(ma_rr % 4), ma_valid_v, ma_data_v});
      check("cycle_b", {b_in_ready, b_fd, b_ptr, b_out_valid, b_out_data},
            {mb_ready, mb_fd, 3'(mb_rr % 8), mb_valid_v, mb_data_v});
   end

   // ---------------- directed stimulus ----------------
   logic [3:0] rr_words;
   int fd_cnt;

   initial begin
      rr_words = 4'b0101;   // beat i carries rr_words[i]: 1,0,1,0
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      check("reset_valid", 64'(a_out_valid), 64'd0);
      check("reset_ptr",   64'(a_ptr), 64'd0);
      check("reset_ready", 64'(a_in_ready), 64'd1);

      // Round-robin ordering
      a_oready = 4'hF; a_rr = 1'b1; a_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_in_data = rr_words[i];
         @(negedge clk);
         check("rr_ptr",   64'(a_ptr), 64'((i + 1) % 4));
         check("rr_valid", 64'(a_out_valid), 64'(4'b0001 << i));
         check("rr_word",  64'(a_out_data[i]), 64'(rr_words[i]));
         check("rr_fd",    64'(a_fd), 64'(i == 3));
      end
      a_in_valid = 1'b0;
      @(negedge clk);
      check("rr_fd_end", 64'(a_fd), 64'd0);

      // Explicit select
      a_rr = 1'b0; a_oready = 4'h0; a_in_valid = 1'b1;
      a_in_data = 1'b1; a_in_sel = 2'd2; @(negedge clk);
      a_in_data = 1'b1; a_in_sel = 2'd0; @(negedge clk);
      check("exp_valid", 64'(a_out_valid), 64'h5);
      check("exp_data",  64'(a_out_data), 64'h5);
      check("exp_ptr",   64'(a_ptr), 64'd0);
      a_in_data = 1'b0; a_in_sel = 2'd2; #1;
      check("exp_blocked", 64'(a_in_ready), 64'd0);
      @(negedge clk);
      check("exp_not_latched", 64'(a_out_data), 64'h5);
      a_in_valid = 1'b0; a_oready = 4'hF; @(negedge clk);

      // Backpressure and same-cycle reload on lane 1
      a_oready = 4'h0; a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_data = 1'b1;
      @(negedge clk);
      a_in_data = 1'b0; #1;
      check("bp_ready_low", 64'(a_in_ready), 64'd0);
      @(negedge clk);
      check("bp_hold", 64'({a_out_valid[1], a_out_data[1]}), 64'b11);
      a_oready = 4'b0010; #1;
      check("bp_ready_high", 64'(a_in_ready), 64'd1);
      @(negedge clk);
      check("bp_reload", 64'({a_out_valid[1], a_out_data[1]}), 64'b10);
      a_in_valid = 1'b0; a_oready = 4'hF; @(negedge clk);

      // Round-robin stall at ptr=2
      a_oready = 4'b0000; a_in_sel = 2'd2; a_in_data = 1'b1; a_in_valid = 1'b1;
      @(negedge clk);
      a_oready = 4'b0011; a_rr = 1'b1; a_in_data = 1'b1;
      @(negedge clk); @(negedge clk);
      a_in_data = 1'b0; #1;
      check("stall_ready", 64'(a_in_ready), 64'd0);
      check("stall_ptr0",  64'(a_ptr), 64'd2);
      @(negedge clk); @(negedge clk);
      check("stall_ptr1",  64'(a_ptr), 64'd2);
      a_oready = 4'b0111; #1;
      check("stall_release", 64'(a_in_ready), 64'd1);
      @(negedge clk);
      check("stall_ptr3", 64'(a_ptr), 64'd3);
      check("stall_word", 64'({a_out_valid[2], a_out_data[2]}), 64'b10);
      a_in_valid = 1'b0; a_oready = 4'hF; @(negedge clk);

      // Mid-frame asynchronous reset (ptr=3: beats land in 3, 0, 1)
      a_in_valid = 1'b1; a_in_data = 1'b1;
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("pre_reset_ptr", 64'(a_ptr), 64'd2);
      a_in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_valid", 64'(a_out_valid), 64'd0);
      check("async_ptr",   64'(a_ptr), 64'd0);
      check("async_fd",    64'(a_fd), 64'd0);
      check("async_data",  64'(a_out_data), 64'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = 1'b1;
      @(negedge clk);
      check("post_reset_lane0", 64'({a_out_valid, a_out_data}), 64'h11);
      check("post_reset_ptr",   64'(a_ptr), 64'd1);
      a_in_valid = 1'b0; @(negedge clk);

      // Wide wrap, lanes never drained: 9th word stalls on lane 0
      b_rr = 1'b1; b_oready = 8'h00; b_in_valid = 1'b1; fd_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         b_in_data = 4'(i);
         @(negedge clk);
         if (b_fd) fd_cnt++;
         check("wrap_fd", 64'(b_fd), 64'(i == 7));
      end
      b_in_data = 4'h8; #1;
      check("wrap_stall_ready", 64'(b_in_ready), 64'd0);
      @(negedge clk);
      if (b_fd) fd_cnt++;
      check("wrap_fd_count", 64'(fd_cnt), 64'd1);
      check("wrap_ptr0",  64'(b_ptr), 64'd0);
      check("wrap_lanes", 64'(b_out_data), 64'h76543210);
      check("wrap_full",  64'(b_out_valid), 64'hFF);
      b_oready = 8'h01; #1;
      check("wrap_release", 64'(b_in_ready), 64'd1);
      @(negedge clk);
      check("wrap_lane0_8", 64'(b_out_data[3:0]), 64'h8);
      check("wrap_ptr1",    64'(b_ptr), 64'd1);
      check("wrap_no_fd",   64'(b_fd), 64'd0);
      b_in_valid = 1'b0; b_oready = 8'hFF;
      @(negedge clk); @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
